// File: rtl/spi_16bit_interface.sv
// Mode-3 SPI master running one 16-bit full-duplex frame per start request (ADXL345 framing).
// Build option SPI_LOOPBACK_EN: receive path samples the internal mosi instead of the miso pin.
module spi_16bit_interface #(
   parameter int CLK_DIV = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] tx_data,
   output logic [15:0] rx_data,
   output logic        busy,
   output logic        done,
   output logic        sclk,
   output logic        cs_n,
   output logic        mosi,
   input  logic        miso
);

   // state   | meaning
   // S_IDLE  | waiting for start, cs_n high, sclk high
   // S_LOAD  | tx word captured, cs_n drops on the next edge
   // S_SETUP | cs_n low, sclk high for one half-period before the first falling edge
   // S_SHIFT | 16 bit periods, low half then high half, miso sampled on the rise
   // S_HOLD  | sclk high, cs_n low for one half-period after the last rise
   // S_GAP   | cs_n high, still busy, enforces minimum deselect time
   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETUP,
      S_SHIFT,
      S_HOLD,
      S_GAP
   } state_t;

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

   state_t      state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]  bit_q, bit_d;
   logic        phase_q, phase_d;
   logic [15:0] tx_sh_q, tx_sh_d;
   logic [15:0] rx_sh_q, rx_sh_d;
   logic [15:0] rx_data_q, rx_data_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        sclk_q, sclk_d;
   logic        cs_n_q, cs_n_d;
   logic        mosi_q, mosi_d;
   logic        cnt_last;
   logic        rx_bit;

`ifdef SPI_LOOPBACK_EN
   assign rx_bit = mosi_q;
`else
   assign rx_bit = miso;
`endif

   assign cnt_last = (cnt_q == CNT_LAST);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      phase_d   = phase_q;
      tx_sh_d   = tx_sh_q;
      rx_sh_d   = rx_sh_q;
      rx_data_d = rx_data_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      sclk_d    = sclk_q;
      cs_n_d    = cs_n_q;
      mosi_d    = mosi_q;

      case (state_q)
         S_IDLE: begin
            if (start && !busy_q) begin
               tx_sh_d = tx_data;
               state_d = S_LOAD;
            end
         end

         S_LOAD: begin
            cs_n_d  = 1'b0;
            busy_d  = 1'b1;
            mosi_d  = tx_sh_q[15];
            rx_sh_d = '0;
            cnt_d   = '0;
            state_d = S_SETUP;
         end

         S_SETUP: begin
            if (cnt_last) begin
               cnt_d   = '0;
               sclk_d  = 1'b0;
               phase_d = 1'b0;
               bit_d   = 4'd15;
               state_d = S_SHIFT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_SHIFT: begin
            if (!cnt_last) begin
               cnt_d = cnt_q + CW'(1);
            end else begin
               cnt_d = '0;
               if (!phase_q) begin
                  sclk_d  = 1'b1;
                  phase_d = 1'b1;
                  rx_sh_d = {rx_sh_q[14:0], rx_bit};
               end else if (bit_q == 4'd0) begin
                  state_d = S_HOLD;
               end else begin
                  // First falling edge needs no update: mosi already holds bit 15.
                  sclk_d  = 1'b0;
                  phase_d = 1'b0;
                  bit_d   = bit_q - 4'd1;
                  tx_sh_d = {tx_sh_q[14:0], 1'b0};
                  mosi_d  = tx_sh_q[14];
               end
            end
         end

         S_HOLD: begin
            if (cnt_last) begin
               cnt_d     = '0;
               cs_n_d    = 1'b1;
               rx_data_d = rx_sh_q;
               done_d    = 1'b1;
               mosi_d    = 1'b0;
               state_d   = S_GAP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_GAP: begin
            if (cnt_last) begin
               cnt_d   = '0;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         phase_q   <= 1'b0;
         tx_sh_q   <= '0;
         rx_sh_q   <= '0;
         rx_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sclk_q    <= 1'b1;
         cs_n_q    <= 1'b1;
         mosi_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         phase_q   <= phase_d;
         tx_sh_q   <= tx_sh_d;
         rx_sh_q   <= rx_sh_d;
         rx_data_q <= rx_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         sclk_q    <= sclk_d;
         cs_n_q    <= cs_n_d;
         mosi_q    <= mosi_d;
      end
   end

   assign rx_data = rx_data_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign sclk    = sclk_q;
   assign cs_n    = cs_n_q;
   assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_16bit_interface.sv
// Directed bench for spi_16bit_interface: reset, frame vectors, ignored start, mid-transfer abort.
module tb_spi_16bit_interface;

   localparam int CLK_DIV = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] tx_data = 16'h0;
   logic [15:0] rx_data;
   logic        busy;
   logic        done;
   logic        sclk;
   logic        cs_n;
   logic        mosi;
   logic        miso;

   int checks = 0;
   int errors = 0;

   // Slave model: drives slv_word MSB first, advancing on each sclk fall.
   logic [15:0] slv_word = 16'h0;
   int          slv_idx  = 16;
   int          rise_cnt = 0;
   int          fall_cnt = 0;
   logic [15:0] mosi_cap = 16'h0;

   spi_16bit_interface #(.CLK_DIV(CLK_DIV)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .tx_data (tx_data),
      .rx_data (rx_data),
      .busy    (busy),
      .done    (done),
      .sclk    (sclk),
      .cs_n    (cs_n),
      .mosi    (mosi),
      .miso    (miso)
   );

   always #5 clk = ~clk;

   assign miso = (slv_idx >= 0 && slv_idx <= 15) ? slv_word[slv_idx[3:0]] : 1'b0;

   always @(negedge sclk or negedge cs_n) begin
      if (sclk) begin
         slv_idx = 16;
      end else if (!cs_n) begin
         slv_idx  = slv_idx - 1;
         fall_cnt = fall_cnt + 1;
      end
   end

   always @(posedge sclk) begin
      if (!cs_n) begin
         mosi_cap = {mosi_cap[14:0], mosi};
         rise_cnt = rise_cnt + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s actual %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_xfer(input string tag, input logic [15:0] tx, input logic [15:0] mw,
                           input logic [15:0] exp_rx, input int inject_at);
      int lat, done_lat, cs_low, busy_lat, done_cnt, busy_gap, stray, rise0, fall0;
      lat = 0; done_lat = -1; cs_low = 0; busy_lat = -1;
      done_cnt = 0; busy_gap = 0; stray = 0;
      rise0 = rise_cnt;
      fall0 = fall_cnt;
      @(negedge clk);
      slv_word = mw;
      tx_data  = tx;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start   = 1'b0;
      tx_data = 16'h0;
      while (busy_lat < 0 && lat < 2000) begin
         @(posedge clk);
         lat = lat + 1;
         @(negedge clk);
         if (inject_at > 0 && lat == inject_at) begin
            start   = 1'b1;
            tx_data = ~tx;
         end else begin
            start = 1'b0;
         end
         if (!cs_n) cs_low = cs_low + 1;
         if (done) begin
            done_cnt = done_cnt + 1;
            if (done_lat < 0) done_lat = lat;
         end
         if (done_lat < 0 && !busy) busy_gap = busy_gap + 1;
         if (done_lat >= 0 && !busy && busy_lat < 0) busy_lat = lat - done_lat;
      end
      start = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (done) done_cnt = done_cnt + 1;
         if (!cs_n) stray = stray + 1;
      end
      chk({tag, "_done_lat"}, done_lat, 34 * CLK_DIV + 1);
      chk({tag, "_cs_low"}, cs_low, 34 * CLK_DIV);
      chk({tag, "_busy_fall"}, busy_lat, CLK_DIV);
      chk({tag, "_done_cnt"}, done_cnt, 1);
      chk({tag, "_busy_gap"}, busy_gap, 0);
      chk({tag, "_stray_cs"}, stray, 0);
      chk({tag, "_rises"}, rise_cnt - rise0, 16);
      chk({tag, "_falls"}, fall_cnt - fall0, 16);
      chk({tag, "_mosi"}, {16'h0, mosi_cap}, {16'h0, tx});
      chk({tag, "_rx"}, {16'h0, rx_data}, {16'h0, exp_rx});
   endtask

   typedef struct {
      string       tag;
      logic [15:0] tx;
      logic [15:0] miso_w;
      logic [15:0] rx_pin;
      logic [15:0] rx_lb;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int bad, rise0, waited, done_seen, cs_seen;
      logic [15:0] exp_rx;

      vecs[0] = '{"wr_2d08", 16'h2D08, 16'h0000, 16'h0000, 16'h2D08};
      vecs[1] = '{"rd_devid", 16'h8000, 16'h00E5, 16'h00E5, 16'h8000};
      vecs[2] = '{"a55a", 16'hA55A, 16'hFFFF, 16'hFFFF, 16'hA55A};
      vecs[3] = '{"mixed", 16'h1234, 16'hC3A5, 16'hC3A5, 16'h1234};

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cs_n", {31'h0, cs_n}, 32'd1);
      chk("rst_sclk", {31'h0, sclk}, 32'd1);
      chk("rst_mosi", {31'h0, mosi}, 32'd0);
      chk("rst_busy", {31'h0, busy}, 32'd0);
      chk("rst_done", {31'h0, done}, 32'd0);
      chk("rst_rx", {16'h0, rx_data}, 32'h0);
      rst_n = 1'b1;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (cs_n !== 1'b1 || sclk !== 1'b1 || mosi !== 1'b0 || busy !== 1'b0 ||
             done !== 1'b0 || rx_data !== 16'h0)
            bad = bad + 1;
      end
      chk("idle_stable", bad, 0);

      // Abort after 8 rising sclk edges, while sclk is in its high half.
      rise0 = rise_cnt;
      @(negedge clk);
      slv_word = 16'hFFFF;
      tx_data  = 16'hFFFF;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waited = 0;
      while (rise_cnt - rise0 < 8 && waited < 1000) begin
         @(negedge clk);
         waited = waited + 1;
      end
      chk("abort_rises", rise_cnt - rise0, 8);
      chk("abort_pre_sclk", {31'h0, sclk}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_cs_n", {31'h0, cs_n}, 32'd1);
      chk("abort_sclk", {31'h0, sclk}, 32'd1);
      chk("abort_busy", {31'h0, busy}, 32'd0);
      chk("abort_mosi", {31'h0, mosi}, 32'd0);
      rst_n = 1'b1;
      done_seen = 0;
      cs_seen = 0;
      repeat (400) begin
         @(negedge clk);
         if (done) done_seen = done_seen + 1;
         if (!cs_n) cs_seen = cs_seen + 1;
      end
      chk("abort_no_done", done_seen, 0);
      chk("abort_no_cs", cs_seen, 0);
      chk("abort_rx", {16'h0, rx_data}, 32'h0);

      for (int i = 0; i < 4; i++) begin
`ifdef SPI_LOOPBACK_EN
         exp_rx = vecs[i].rx_lb;
`else
         exp_rx = vecs[i].rx_pin;
`endif
         run_xfer(vecs[i].tag, vecs[i].tx, vecs[i].miso_w, exp_rx, 0);
      end

      // Second start 50 cycles into a frame must be ignored.
`ifdef SPI_LOOPBACK_EN
      exp_rx = 16'h0F0F;
`else
      exp_rx = 16'h5A5A;
`endif
      run_xfer("ignored_start", 16'h0F0F, 16'h5A5A, exp_rx, 50);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual running expected finished");
      $fatal(1, "timeout");
   end

endmodule
